// File: rtl/qspi_flash_pkg.sv
// Shared opcode, phase bit counts, FSM state type and helpers for qspi_flash_reader.
// Optional feature macro: FLASH_BURST_EN (adds the STREAM state).
package qspi_flash_pkg;

    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam logic [5:0] CMD_BITS  = 6'd8;
    localparam logic [5:0] ADDR_BITS = 6'd24;
    localparam logic [5:0] DATA_BITS = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RESP,
        GAP
`ifdef FLASH_BURST_EN
        ,
        STREAM
`endif
    } state_t;

    // Flash returns the lowest-addressed byte first, so it lands in the top byte of the shifter.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// MSB-first SPI shift register shared by the command, address and data phases.
// Loads a word and a bit count, shifts one bit per request, flags the final bit.
module spi_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [5:0]  load_bits,
    input  logic        shift,
    input  logic        sin,
    output logic        sout,
    output logic [31:0] word,
    output logic        done
);

    logic [31:0] sreg;
    logic [5:0]  count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            count <= '0;
        end else if (load) begin
            sreg  <= load_data;
            count <= load_bits;
        end else if (shift) begin
            sreg  <= {sreg[30:0], sin};
            count <= count - 6'd1;
        end
    end

    assign sout = sreg[31];
    // Word as it will stand after the current shift, so the last received bit is included.
    assign word = {sreg[30:0], sin};
    assign done = (count == 6'd1);

endmodule

// File: rtl/qspi_flash_reader.sv
// Word reader for a SPI NOR flash using the 0x03 read command, SPI mode 0, 2 clk per bit.
// Optional feature macro: FLASH_BURST_EN keeps cs low after a read so the next sequential word streams.
module qspi_flash_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        cs,
    output logic        sclk,
    output logic        si,
    input  logic        so,
    output logic        wp,
    output logic        hold
);

    import qspi_flash_pkg::*;

    state_t      state, state_next;
    logic        phase, phase_next;
    logic [23:0] addr, addr_next;
    logic        load, shift, done, sout, word_done;
    logic [31:0] load_data, word;
    logic [5:0]  load_bits;
    logic        shifting;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];

    spi_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_bits (load_bits),
        .shift     (shift),
        .sin       (so),
        .sout      (sout),
        .word      (word),
        .done      (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            addr       <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            addr       <= addr_next;
            resp_valid <= word_done;
            if (word_done) begin
                resp_data <= byte_swap(word);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        phase_next = 1'b0;
        addr_next  = addr;
        load       = 1'b0;
        load_data  = '0;
        load_bits  = '0;
        shift      = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = {req_addr[23:2], 2'b00};
                    load       = 1'b1;
                    load_data  = {READ_CMD, 24'h0};
                    load_bits  = CMD_BITS;
                    state_next = CMD;
                end
            end
            CMD, ADDR, DATA: begin
                // phase 0 is the sclk-low half, phase 1 the sclk-high half ending in a sample.
                phase_next = ~phase;
                shift      = phase;
                if (phase && done) begin
                    if (state == CMD) begin
                        load       = 1'b1;
                        load_data  = {addr, 8'h00};
                        load_bits  = ADDR_BITS;
                        state_next = ADDR;
                    end else if (state == ADDR) begin
                        load       = 1'b1;
                        load_bits  = DATA_BITS;
                        state_next = DATA;
                    end else begin
                        word_done  = 1'b1;
`ifdef FLASH_BURST_EN
                        state_next = STREAM;
`else
                        state_next = RESP;
`endif
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            GAP: begin
                phase_next = ~phase;
                if (phase) begin
                    load       = 1'b1;
                    load_data  = {READ_CMD, 24'h0};
                    load_bits  = CMD_BITS;
                    state_next = CMD;
                end
            end
`ifdef FLASH_BURST_EN
            STREAM: begin
                if (req_valid) begin
                    addr_next = {req_addr[23:2], 2'b00};
                    // The flash is already positioned at addr+4, so a sequential word needs only clocks.
                    if (req_addr[23:2] == addr[23:2] + 22'd1) begin
                        load       = 1'b1;
                        load_bits  = DATA_BITS;
                        state_next = DATA;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);

`ifdef FLASH_BURST_EN
    assign cs        = ~(shifting || (state == STREAM));
    assign req_ready = ~rst && ((state == IDLE) || (state == STREAM));
`else
    assign cs        = ~shifting;
    assign req_ready = ~rst && (state == IDLE);
`endif

    assign sclk = shifting && phase;
    assign si   = ((state == CMD) || (state == ADDR)) ? sout : 1'b0;
    assign wp   = 1'b1;
    assign hold = 1'b1;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench for qspi_flash_reader against a behavioural SPI read-command flash buffer.
// Build with FLASH_BURST_EN defined to exercise the streaming sequence instead of the default one.
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        cs, sclk, si, wp, hold;
    logic        so = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    qspi_flash_reader dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .cs         (cs),
        .sclk       (sclk),
        .si         (si),
        .so         (so),
        .wp         (wp),
        .hold       (hold)
    );

    always #5 clk = ~clk;

    // ---------------- flash buffer mock ----------------
    logic [7:0]  mem [256];
    int          bit_cnt  = 0;
    logic [31:0] hdr      = '0;
    logic [31:0] last_hdr = '0;
    logic [23:0] rd_ptr   = '0;
    int          data_bit = 0;
    logic        started  = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h70;
        mem[3] = 8'h30;
    end

    always @(sclk or cs) begin
        if (cs !== 1'b0) begin
            bit_cnt = 0;
            started = 1'b0;
        end else if (sclk === 1'b1) begin
            if (bit_cnt < 32) begin
                hdr = {hdr[30:0], si};
                bit_cnt++;
                if (bit_cnt == 32) last_hdr = hdr;
            end
        end else if (bit_cnt == 32) begin
            if (!started) begin
                rd_ptr   = hdr[23:0];
                data_bit = 0;
                started  = 1'b1;
            end
            so = mem[rd_ptr[7:0]][7 - data_bit];
            if (data_bit == 7) begin
                data_bit = 0;
                rd_ptr   = rd_ptr + 24'd1;
            end else begin
                data_bit++;
            end
        end
    end

    // Length of the most recent completed cs-high run, in clk cycles.
    int cs_run   = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if (cs === 1'b1) begin
            cs_run++;
        end else begin
            if (cs_run > 0) last_gap = cs_run;
            cs_run = 0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int   r_wait, r_lat, r_low, r_high;
    logic r_cs_resp, r_sclk_resp, r_ready_resp;

    // Entered at a negedge; returns just after the accepting posedge.
    task automatic accept(input logic [23:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        r_wait    = 0;
        while (req_ready !== 1'b1 && r_wait < 400) begin
            @(negedge clk);
            r_wait++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '0;
    endtask

    // Entered at a negedge; returns at the negedge of the resp_valid cycle (or on timeout).
    task automatic run_read(input logic [23:0] a);
        accept(a);
        r_lat  = 0;
        r_low  = 0;
        r_high = 0;
        while (r_lat < 300) begin
            @(negedge clk);
            r_lat++;
            if (resp_valid === 1'b1) break;
            if (cs === 1'b0) r_low++;
            else r_high++;
        end
        r_cs_resp    = cs;
        r_sclk_resp  = sclk;
        r_ready_resp = req_ready;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int resp_seen;

        #1 rst = 1'b1;
        #1;
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_si", 32'(si), 32'd0);
        check("rst_wp", 32'(wp), 32'd1);
        check("rst_hold", 32'(hold), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

`ifdef FLASH_BURST_EN
        run_read(24'h000000);
        check("b0_lat", 32'(r_lat), 32'd129);
        check("b0_data", resp_data, 32'h30700513);
        check("b0_cs_low", 32'(r_low), 32'd128);
        check("b0_cs_at_resp", 32'(r_cs_resp), 32'd0);
        check("b0_ready_at_resp", 32'(r_ready_resp), 32'd1);

        run_read(24'h000004);
        check("b1_wait", 32'(r_wait), 32'd0);
        check("b1_lat", 32'(r_lat), 32'd65);
        check("b1_cs_high", 32'(r_high), 32'd0);
        check("b1_data", resp_data, 32'h07060504);

        run_read(24'h000020);
        check("b2_lat", 32'(r_lat), 32'd131);
        check("b2_cs_high", 32'(r_high), 32'd2);
        check("b2_cs_low", 32'(r_low), 32'd128);
        check("b2_data", resp_data, 32'h23222120);

        run_read(24'hFFFFFC);
        check("b3_lat", 32'(r_lat), 32'd131);
        check("b3_data", resp_data, 32'hFFFEFDFC);
        check("b3_hdr", last_hdr, 32'h03FFFFFC);

        run_read(24'h000000);
        check("b4_wrap_lat", 32'(r_lat), 32'd65);
        check("b4_wrap_cs_high", 32'(r_high), 32'd0);
        check("b4_wrap_data", resp_data, 32'h30700513);

        repeat (20) @(negedge clk);
        check("stream_hold_cs", 32'(cs), 32'd0);
        check("stream_hold_ready", 32'(req_ready), 32'd1);
        check("stream_hold_sclk", 32'(sclk), 32'd0);
`else
        run_read(24'h000000);
        check("r0_lat", 32'(r_lat), 32'd129);
        check("r0_data", resp_data, 32'h30700513);
        check("r0_cs_low", 32'(r_low), 32'd128);
        check("r0_cs_high", 32'(r_high), 32'd0);
        check("r0_cs_at_resp", 32'(r_cs_resp), 32'd1);
        check("r0_sclk_at_resp", 32'(r_sclk_resp), 32'd0);
        check("r0_ready_at_resp", 32'(r_ready_resp), 32'd0);
        check("r0_si_hdr", last_hdr, 32'h03000000);

        run_read(24'h000004);
        check("b2b1_wait", 32'(r_wait), 32'd1);
        check("b2b1_gap", 32'(last_gap), 32'd2);
        check("b2b1_lat", 32'(r_lat), 32'd129);
        check("b2b1_data", resp_data, 32'h07060504);

        run_read(24'h000008);
        check("b2b2_gap", 32'(last_gap), 32'd2);
        check("b2b2_lat", 32'(r_lat), 32'd129);
        check("b2b2_data", resp_data, 32'h0B0A0908);

        @(negedge clk);
        check("hold_valid_low", 32'(resp_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("hold_data", resp_data, 32'h0B0A0908);

        run_read(24'h000007);
        check("lsb_hdr", last_hdr, 32'h03000004);
        check("lsb_data", resp_data, 32'h07060504);

        @(negedge clk);
        accept(24'h000000);
        repeat (60) @(negedge clk);
        check("abort_busy_cs", 32'(cs), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        resp_seen = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) resp_seen++;
        end
        check("abort_no_resp", 32'(resp_seen), 32'd0);

        run_read(24'h000010);
        check("after_abort_lat", 32'(r_lat), 32'd129);
        check("after_abort_data", resp_data, 32'h13121110);

        @(negedge clk);
        run_read(24'hFFFFFC);
        check("top_hdr", last_hdr, 32'h03FFFFFC);
        check("top_data", resp_data, 32'hFFFEFDFC);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
